cvrt_bin_gry_pipe: RTL and testbench

//  Streaming binary-to-Gray encoder with valid/ready on both sides; pairs with the Gray-to-binary converter.

---
 rtl/cvrt_pkg.sv | 17 +
 rtl/cvrt_bin_gry.sv | 12 +
 rtl/cvrt_bin_gry_pipe.sv | 98 +++++++++
 tb/tb_cvrt_bin_gry_pipe.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/cvrt_pkg.sv
// Shared helpers for the binary<->Gray converter pair.
// Functions take words zero-extended to CVRT_MAX_W so both converter sides can reuse them at any width.
package cvrt_pkg;

  localparam int CVRT_MAX_W = 32;

  function automatic logic [CVRT_MAX_W-1:0] f_bin2gry(input logic [CVRT_MAX_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // True when a and b differ in exactly one bit position.
  function automatic logic f_onehot_diff(input logic [CVRT_MAX_W-1:0] a,
                                         input logic [CVRT_MAX_W-1:0] b);
    return ($countones(a ^ b) == 1);
  endfunction

endpackage

// File: rtl/cvrt_bin_gry.sv
// Pure combinational binary-to-Gray encoder; MSB passes through unchanged.
module cvrt_bin_gry #(
  parameter int DATA_WIDTH = 4
) (
  input  logic [DATA_WIDTH-1:0] i_bin,
  output logic [DATA_WIDTH-1:0] o_gry
);
  import cvrt_pkg::*;

  assign o_gry = DATA_WIDTH'(f_bin2gry(CVRT_MAX_W'(i_bin)));

endmodule

// File: rtl/cvrt_bin_gry_pipe.sv
// Streaming binary-to-Gray encoder with a registered output stage, one-entry skid buffer,
// and a flag marking single-bit steps between consecutively delivered words.
module cvrt_bin_gry_pipe #(
  parameter int DATA_WIDTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_bin_vld,
  output logic                  o_bin_rdy,
  input  logic [DATA_WIDTH-1:0] i_bin,
  output logic                  o_gry_vld,
  input  logic                  i_gry_rdy,
  output logic [DATA_WIDTH-1:0] o_gry,
  output logic                  o_step
);
  import cvrt_pkg::*;

  logic [DATA_WIDTH-1:0] enc;
  logic [DATA_WIDTH-1:0] main_q, main_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;
  logic [DATA_WIDTH-1:0] last_q, last_d;
  logic                  main_vld_q, main_vld_d;
  logic                  skid_vld_q, skid_vld_d;
  logic                  has_last_q, has_last_d;
  logic                  rdy_q, rdy_d;
  logic                  in_xfer, out_xfer;

  cvrt_bin_gry #(.DATA_WIDTH(DATA_WIDTH)) u_enc (
    .i_bin (i_bin),
    .o_gry (enc)
  );

  // Ready comes from a flop (no rdy->rdy path) but is forced low while reset is held.
  assign o_bin_rdy = rdy_q & ~i_rst;
  assign o_gry_vld = main_vld_q;
  assign o_gry     = main_q;
  assign in_xfer   = i_bin_vld & o_bin_rdy;
  assign out_xfer  = main_vld_q & i_gry_rdy;
  assign o_step    = main_vld_q & has_last_q &
                     f_onehot_diff(CVRT_MAX_W'(main_q), CVRT_MAX_W'(last_q));

  always_comb begin
    main_d     = main_q;
    main_vld_d = main_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    last_d     = last_q;
    has_last_d = has_last_q;

    if (!main_vld_q) begin
      if (in_xfer) begin
        main_d     = enc;
        main_vld_d = 1'b1;
      end
    end else if (out_xfer) begin
      if (skid_vld_q) begin
        main_d = skid_q;
        if (in_xfer) skid_d     = enc;
        else         skid_vld_d = 1'b0;
      end else if (in_xfer) begin
        main_d = enc;
      end else begin
        main_vld_d = 1'b0;
      end
    end else if (in_xfer) begin
      skid_d     = enc;
      skid_vld_d = 1'b1;
    end

    if (out_xfer) begin
      last_d     = main_q;
      has_last_d = 1'b1;
    end

    rdy_d = ~skid_vld_d;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      main_q     <= '0;
      main_vld_q <= 1'b0;
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
      last_q     <= '0;
      has_last_q <= 1'b0;
      rdy_q      <= 1'b1;
    end else begin
      main_q     <= main_d;
      main_vld_q <= main_vld_d;
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
      last_q     <= last_d;
      has_last_q <= has_last_d;
      rdy_q      <= rdy_d;
    end
  end

endmodule

// File: tb/tb_cvrt_bin_gry_pipe.sv
// Directed and randomized-handshake checks for the binary-to-Gray pipeline.
module tb_cvrt_bin_gry_pipe;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_bin_vld;
  logic       o_bin_rdy;
  logic [3:0] i_bin;
  logic       o_gry_vld;
  logic       i_gry_rdy;
  logic [3:0] o_gry;
  logic       o_step;

  int n_checks = 0;
  int n_fail   = 0;

  cvrt_bin_gry_pipe #(.DATA_WIDTH(4)) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_bin_vld (i_bin_vld),
    .o_bin_rdy (o_bin_rdy),
    .i_bin     (i_bin),
    .o_gry_vld (o_gry_vld),
    .i_gry_rdy (i_gry_rdy),
    .o_gry     (o_gry),
    .o_step    (o_step)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [3:0] model_gry(input logic [3:0] b);
    return b ^ {1'b0, b[3:1]};
  endfunction

  logic [3:0] gray_tab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

  initial begin
    int send_cnt, recv_cnt, cycles;
    logic in_x, out_x, hold_pend;
    logic [3:0] hold_val, prev_gry;

    // Reset
    i_rst = 1'b1; i_bin_vld = 1'b0; i_bin = '0; i_gry_rdy = 1'b1;
    tick(); tick();
    check("rst_rdy_low", 32'(o_bin_rdy), 32'd0);
    check("rst_vld", 32'(o_gry_vld), 32'd0);
    check("rst_gry", 32'(o_gry), 32'd0);
    check("rst_step", 32'(o_step), 32'd0);
    i_rst = 1'b0;
    #1;
    check("post_rst_rdy", 32'(o_bin_rdy), 32'd1);

    // Stream 0..15 at full rate
    for (int k = 0; k < 16; k++) begin
      i_bin_vld = 1'b1; i_bin = 4'(k);
      tick();
      check($sformatf("stream_vld_%0d", k), 32'(o_gry_vld), 32'd1);
      check($sformatf("stream_gry_%0d", k), 32'(o_gry), 32'(gray_tab[k]));
      check($sformatf("stream_step_%0d", k), 32'(o_step), (k == 0) ? 32'd0 : 32'd1);
    end
    i_bin_vld = 1'b0;
    tick();
    check("stream_drain", 32'(o_gry_vld), 32'd0);

    // Wrap: 15 repeats last word (step 0), then 0 is a single-bit step
    i_bin_vld = 1'b1; i_bin = 4'd15;
    tick();
    check("wrap_gry15", 32'(o_gry), 32'h8);
    check("wrap_step15", 32'(o_step), 32'd0);
    i_bin = 4'd0;
    tick();
    check("wrap_gry0", 32'(o_gry), 32'h0);
    check("wrap_step0", 32'(o_step), 32'd1);
    i_bin_vld = 1'b0;
    tick();

    // Backpressure: 3 into main, 4 into skid, 5 held off
    i_gry_rdy = 1'b0; i_bin_vld = 1'b1; i_bin = 4'd3;
    tick();
    check("bp_gry_a", 32'(o_gry), 32'h2);
    check("bp_rdy_a", 32'(o_bin_rdy), 32'd1);
    i_bin = 4'd4;
    tick();
    check("bp_rdy_b", 32'(o_bin_rdy), 32'd0);
    check("bp_hold_b", 32'(o_gry), 32'h2);
    i_bin = 4'd5;
    tick();
    check("bp_rdy_c", 32'(o_bin_rdy), 32'd0);
    check("bp_hold_c", 32'(o_gry), 32'h2);
    check("bp_vld_c", 32'(o_gry_vld), 32'd1);
    check("bp_step_c", 32'(o_step), 32'd1);
    i_gry_rdy = 1'b1;
    tick();
    check("bp_gry_d", 32'(o_gry), 32'h6);
    check("bp_step_d", 32'(o_step), 32'd1);
    check("bp_rdy_d", 32'(o_bin_rdy), 32'd1);
    tick();
    check("bp_gry_e", 32'(o_gry), 32'h7);
    check("bp_step_e", 32'(o_step), 32'd1);
    i_bin_vld = 1'b0;
    tick();
    check("bp_drain", 32'(o_gry_vld), 32'd0);

    // Non-step sequences: 0,2 then 5,5
    i_bin_vld = 1'b1; i_bin = 4'd0;
    tick();
    check("ns_gry0", 32'(o_gry), 32'h0);
    check("ns_step0", 32'(o_step), 32'd0);
    i_bin = 4'd2;
    tick();
    check("ns_gry3", 32'(o_gry), 32'h3);
    check("ns_step3", 32'(o_step), 32'd0);
    i_bin = 4'd5;
    tick();
    check("ns_gry7a", 32'(o_gry), 32'h7);
    check("ns_step7a", 32'(o_step), 32'd1);
    tick();
    check("ns_gry7b", 32'(o_gry), 32'h7);
    check("ns_step7b", 32'(o_step), 32'd0);
    i_bin_vld = 1'b0;
    tick();

    // Random vld/rdy with 1000 sequential counts starting at 6 (continues from 5)
    send_cnt = 0; recv_cnt = 0; cycles = 0; hold_pend = 1'b0; hold_val = '0;
    prev_gry = 4'h7;
    while (recv_cnt < 1000 && cycles < 20000) begin
      i_bin_vld = (send_cnt < 1000) && ($urandom_range(0, 3) != 0);
      i_bin     = i_bin_vld ? 4'(6 + send_cnt) : 4'($urandom_range(0, 15));
      i_gry_rdy = ($urandom_range(0, 2) != 0);
      #1;
      if (hold_pend) begin
        check("rnd_hold_vld", 32'(o_gry_vld), 32'd1);
        check("rnd_hold_gry", 32'(o_gry), 32'(hold_val));
      end
      in_x  = i_bin_vld & o_bin_rdy;
      out_x = o_gry_vld & i_gry_rdy;
      if (out_x) begin
        check("rnd_gry", 32'(o_gry), 32'(model_gry(4'(6 + recv_cnt))));
        check("rnd_step", 32'(o_step), 32'd1);
        check("rnd_step_model", 32'($countones(o_gry ^ prev_gry) == 1), 32'd1);
        prev_gry = o_gry;
        recv_cnt++;
      end
      hold_pend = o_gry_vld & ~i_gry_rdy;
      hold_val  = o_gry;
      if (in_x) send_cnt++;
      tick();
      cycles++;
    end
    check("rnd_count", 32'(recv_cnt), 32'd1000);
    i_bin_vld = 1'b0; i_gry_rdy = 1'b1;
    tick(); tick();
    check("rnd_drain", 32'(o_gry_vld), 32'd0);

    // Reset with main and skid both full
    i_gry_rdy = 1'b0; i_bin_vld = 1'b1; i_bin = 4'd9;
    tick();
    i_bin = 4'd10;
    tick();
    check("mr_full_rdy", 32'(o_bin_rdy), 32'd0);
    i_rst = 1'b1; i_bin_vld = 1'b0;
    #1;
    check("mr_rdy_in_rst", 32'(o_bin_rdy), 32'd0);
    tick();
    check("mr_vld", 32'(o_gry_vld), 32'd0);
    check("mr_step", 32'(o_step), 32'd0);
    check("mr_gry", 32'(o_gry), 32'd0);
    i_rst = 1'b0;
    #1;
    check("mr_rdy", 32'(o_bin_rdy), 32'd1);
    i_gry_rdy = 1'b1; i_bin_vld = 1'b1; i_bin = 4'd1;
    tick();
    check("mr_first_gry", 32'(o_gry), 32'h1);
    check("mr_first_step", 32'(o_step), 32'd0);
    i_bin_vld = 1'b0;
    tick();
    check("mr_drain", 32'(o_gry_vld), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
